// File: rtl/pipearch_arb_pkg.sv
// Purpose: shared arbitration types and the round-robin pick helper.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package pipearch_arb_pkg;

  // IDs are stored at the width needed for the largest supported requester
  // count (8). This keeps the tag layout identical for every NUM_REQ.
  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_IDW     = 3;

  // One in-flight read: was a read issued in this slot, and who issued it.
  typedef struct packed {
    logic               valid;
    logic [ARB_IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic               found;
    logic [ARB_IDW-1:0] idx;
  } pick_t;

  // Returns the first asserted bit of req[n-1:0], scanning upward from ptr
  // and wrapping modulo n.
  function automatic pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                    input logic [ARB_IDW-1:0]     ptr,
                                    input int                     n);
    pick_t r;
    int    j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      j = (int'(ptr) + i) % n;
      if (!r.found && (i < n) && req[j]) begin
        r.found = 1'b1;
        r.idx   = ARB_IDW'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_read_arbiter_rr_arbiter.sv
// Purpose: round-robin arbiter with bounded burst ownership (one grant per cycle).
// Latency: grant is combinational from i_req and state; state updates on the clock edge.
// Backpressure: a requester that is not granted simply waits with its request held.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   i_req           per-requester request
//   o_grant         one-hot grant (zero when no request, or while reset is low)
//   o_grant_vld     a grant is issued this cycle
//   o_grant_id      index of the granted requester
module rr_arbiter
  import pipearch_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_vld,
  output logic [ARB_IDW-1:0] o_grant_id
);

  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic               r_owner_vld;
  logic [ARB_IDW-1:0] r_owner_id;
  logic [BW-1:0]      r_burst_cnt;
  logic [ARB_IDW-1:0] r_rr_ptr;

  logic [NUM_REQ-1:0]     w_owner_oh;
  logic [NUM_REQ-1:0]     w_others;
  logic [NUM_REQ-1:0]     w_mask;
  logic [ARB_MAX_REQ-1:0] w_mask_ext;
  logic                   w_owner_req;
  logic                   w_limit;
  logic                   w_keep;
  pick_t                  w_pick;
  logic                   w_win_vld;
  logic [ARB_IDW-1:0]     w_win_id;
  logic [ARB_IDW-1:0]     w_ptr_nxt;

  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner_id == ARB_IDW'(i)) w_owner_oh[i] = 1'b1;
    end
  end

  assign w_owner_req = r_owner_vld & (|(i_req & w_owner_oh));
  assign w_others    = i_req & ~w_owner_oh;
  assign w_limit     = (r_burst_cnt >= BURST_MAX);
  // The owner keeps the port until its burst is used up, or indefinitely if
  // nobody else is waiting.
  assign w_keep      = w_owner_req & (~w_limit | ~(|w_others));
  // If we get here with the owner still requesting, it hit its limit while
  // someone else waits, so it is taken out of the scan.
  assign w_mask      = w_owner_req ? w_others : i_req;

  always_comb begin
    w_mask_ext                = '0;
    w_mask_ext[NUM_REQ-1:0]   = w_mask;
  end

  assign w_pick    = rr_pick(w_mask_ext, r_rr_ptr, NUM_REQ);
  assign w_win_vld = reset & (w_keep | w_pick.found);
  assign w_win_id  = w_keep ? r_owner_id : w_pick.idx;
  assign w_ptr_nxt = (w_pick.idx == ARB_IDW'(NUM_REQ - 1)) ? '0
                                                            : w_pick.idx + ARB_IDW'(1);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_vld && (w_win_id == ARB_IDW'(i))) o_grant[i] = 1'b1;
    end
  end

  assign o_grant_vld = w_win_vld;
  assign o_grant_id  = w_win_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_vld <= 1'b0;
      r_owner_id  <= '0;
      r_burst_cnt <= '0;
      r_rr_ptr    <= '0;
    end else if (w_keep) begin
      if (!w_limit) r_burst_cnt <= r_burst_cnt + BW'(1);
    end else if (w_pick.found) begin
      r_owner_vld <= 1'b1;
      r_owner_id  <= w_pick.idx;
      r_burst_cnt <= BW'(1);
      r_rr_ptr    <= w_ptr_nxt;
    end else begin
      r_owner_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Purpose: shares one BRAM read port among NUM_REQ requesters and routes each response back to its issuer.
// Latency: accept at t -> bram_re at t+1 -> resp_rvalid at t+1+READ_LATENCY.
// Backpressure: req_ready is the grant; an ungranted request waits, and responses cannot be stalled.
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   req_re / req_raddr       per-requester read request and address (slice i = requester i)
//   req_ready                one-hot grant; accept = req_re[i] & req_ready[i]
//   resp_rvalid / resp_rdata one-hot response valid and shared response data
//   bram_re / bram_raddr     registered BRAM read command
//   bram_rvalid / bram_rdata BRAM read return
//   err_lost                 sticky: an expected response did not arrive
module bram_read_arbiter
  import pipearch_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int WIDTH        = 512,
  parameter int LOG2_DEPTH   = 9,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_re,
  input  logic [NUM_REQ*LOG2_DEPTH-1:0] req_raddr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_rvalid,
  output logic [WIDTH-1:0]              resp_rdata,
  output logic                          bram_re,
  output logic [LOG2_DEPTH-1:0]         bram_raddr,
  input  logic                          bram_rvalid,
  input  logic [WIDTH-1:0]              bram_rdata,
  output logic                          err_lost
);

  logic                  w_grant_vld;
  logic [ARB_IDW-1:0]    w_grant_id;
  logic [LOG2_DEPTH-1:0] w_win_addr;
  tag_t                  w_head;

  logic                  r_bram_re;
  logic [LOG2_DEPTH-1:0] r_bram_raddr;
  logic                  r_err_lost;
  // Slot 0 lines up with bram_re; slot READ_LATENCY lines up with bram_rvalid.
  tag_t                  r_tag [READ_LATENCY+1];

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (req_re),
    .o_grant     (req_ready),
    .o_grant_vld (w_grant_vld),
    .o_grant_id  (w_grant_id)
  );

  always_comb begin
    w_win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) w_win_addr = req_raddr[i*LOG2_DEPTH +: LOG2_DEPTH];
    end
  end

  // The address only matters at accept; it holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bram_re    <= 1'b0;
      r_bram_raddr <= '0;
    end else begin
      r_bram_re <= w_grant_vld;
      if (w_grant_vld) r_bram_raddr <= w_win_addr;
    end
  end

  // Clearing the tags on reset discards in-flight reads, so their late
  // bram_rvalid finds no valid head and is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= READ_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].valid <= w_grant_vld;
      r_tag[0].id    <= w_grant_id;
      for (int k = 1; k <= READ_LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_head = r_tag[READ_LATENCY];

  always_comb begin
    resp_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_rvalid[i] = reset & bram_rvalid & w_head.valid & (w_head.id == ARB_IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err_lost <= 1'b0;
    else        r_err_lost <= r_err_lost | (w_head.valid & ~bram_rvalid);
  end

  assign resp_rdata = bram_rdata;
  assign bram_re    = r_bram_re;
  assign bram_raddr = r_bram_raddr;
  assign err_lost   = r_err_lost;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Purpose: directed checks of bram_read_arbiter at READ_LATENCY=1 (inst A) and READ_LATENCY=3 (inst B).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 4 units after posedge.
// Backpressure: BRAM models always return data READ_LATENCY cycles after bram_re (A can drop one).
module tb_bram_read_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // instance A: READ_LATENCY=1
  logic [N-1:0]    a_re = '0;
  logic [N*AW-1:0] a_addr = '0;
  logic [N-1:0]    a_ready, a_rv;
  logic [W-1:0]    a_rdata, a_brd, a_sd;
  logic            a_bre, a_brv, a_err, a_sv;
  logic [AW-1:0]   a_baddr;
  logic            a_drop = 1'b0;

  // instance B: READ_LATENCY=3
  logic [N-1:0]    b_re = '0;
  logic [N*AW-1:0] b_addr = '0;
  logic [N-1:0]    b_ready, b_rv;
  logic [W-1:0]    b_rdata, b_brd;
  logic            b_bre, b_brv, b_err;
  logic [AW-1:0]   b_baddr;
  logic [2:0]      b_sv;
  logic [W-1:0]    b_sd [3];

  function automatic logic [W-1:0] mem_dat(input logic [AW-1:0] a);
    return 32'h5A00_0000 + 32'(a) * 32'd7919;
  endfunction

  bram_read_arbiter #(.NUM_REQ(N), .WIDTH(W), .LOG2_DEPTH(AW), .READ_LATENCY(1), .MAX_BURST(4)) u_a (
    .clk(clk), .reset(reset), .req_re(a_re), .req_raddr(a_addr), .req_ready(a_ready),
    .resp_rvalid(a_rv), .resp_rdata(a_rdata), .bram_re(a_bre), .bram_raddr(a_baddr),
    .bram_rvalid(a_brv), .bram_rdata(a_brd), .err_lost(a_err));

  bram_read_arbiter #(.NUM_REQ(N), .WIDTH(W), .LOG2_DEPTH(AW), .READ_LATENCY(3), .MAX_BURST(4)) u_b (
    .clk(clk), .reset(reset), .req_re(b_re), .req_raddr(b_addr), .req_ready(b_ready),
    .resp_rvalid(b_rv), .resp_rdata(b_rdata), .bram_re(b_bre), .bram_raddr(b_baddr),
    .bram_rvalid(b_brv), .bram_rdata(b_brd), .err_lost(b_err));

  // BRAM models: not reset, so reads issued before a reset still return.
  always @(posedge clk) begin
    a_sv <= a_bre;
    a_sd <= mem_dat(a_baddr);
    b_sv <= {b_sv[1:0], b_bre};
    b_sd[0] <= mem_dat(b_baddr);
    b_sd[1] <= b_sd[0];
    b_sd[2] <= b_sd[1];
  end
  assign a_brv = a_sv & ~a_drop;
  assign a_brd = a_sd;
  assign b_brv = b_sv[2];
  assign b_brd = b_sd[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic do_reset;
    reset  = 1'b0;
    a_re   = '0;
    b_re   = '0;
    a_drop = 1'b0;
    step();
    step();
    reset  = 1'b1;
  endtask

  task automatic set_a(input int i, input int v);
    a_addr[i*AW +: AW] = AW'(v);
  endtask

  task automatic set_b(input int i, input int v);
    b_addr[i*AW +: AW] = AW'(v);
  endtask

  logic [N-1:0] hist [32];
  logic [N-1:0] t3_re  [5];
  logic [N-1:0] t3_exp [5];
  logic [N-1:0] t5_re  [4];
  int           t5_id  [4];
  logic [N-1:0] e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with requests asserted to show ready stays low
    a_re = 3'b111;
    b_re = 3'b111;
    #4;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_a_bre", a_bre, 0);
    chk("rst_a_baddr", a_baddr, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_rv", b_rv, 0);
    do_reset();

    // T1: single requester, addresses 0..5
    for (int c = 0; c < 9; c++) begin
      a_re = (c < 6) ? 3'b010 : 3'b000;
      set_a(1, c);
      settle();
      chk($sformatf("t1_ready_c%0d", c), a_ready, (c < 6) ? 3'b010 : 3'b000);
      chk($sformatf("t1_bre_c%0d", c), a_bre, (c >= 1 && c <= 6) ? 1 : 0);
      if (c >= 1 && c <= 6) chk($sformatf("t1_baddr_c%0d", c), a_baddr, c - 1);
      chk($sformatf("t1_rv_c%0d", c), a_rv, (c >= 2 && c <= 7) ? 3'b010 : 3'b000);
      if (c >= 2 && c <= 7) chk($sformatf("t1_rdata_c%0d", c), a_rdata, mem_dat(AW'(c - 2)));
      step();
    end

    // T2: three-way contention, bursts of 4 in rotation
    do_reset();
    for (int i = 0; i < N; i++) set_a(i, 100 + i);
    for (int c = 0; c < 28; c++) begin
      a_re = (c < 24) ? 3'b111 : 3'b000;
      settle();
      e = (c < 24) ? N'(1 << ((c / 4) % 3)) : '0;
      hist[c] = e;
      chk($sformatf("t2_ready_c%0d", c), a_ready, e);
      chk($sformatf("t2_onehot_c%0d", c), ($countones(a_ready) <= 1) ? 1 : 0, 1);
      chk($sformatf("t2_rv_c%0d", c), a_rv, (c >= 2) ? hist[c-2] : 3'b000);
      step();
    end

    // T3: owner drop hands over next cycle; rr_ptr wraps to 0
    do_reset();
    t3_re  = '{3'b101, 3'b101, 3'b100, 3'b000, 3'b011};
    t3_exp = '{3'b001, 3'b001, 3'b100, 3'b000, 3'b001};
    for (int c = 0; c < 5; c++) begin
      a_re = t3_re[c];
      settle();
      chk($sformatf("t3_ready_c%0d", c), a_ready, t3_exp[c]);
      step();
    end

    // T4: lone requester beyond MAX_BURST is never interrupted
    do_reset();
    for (int c = 0; c < 12; c++) begin
      a_re = (c < 10) ? 3'b010 : 3'b000;
      settle();
      chk($sformatf("t4_ready_c%0d", c), a_ready, (c < 10) ? 3'b010 : 3'b000);
      chk($sformatf("t4_bre_c%0d", c), a_bre, (c >= 1 && c <= 10) ? 1 : 0);
      step();
    end

    // T6: a missing response sets the sticky error
    do_reset();
    for (int c = 0; c < 6; c++) begin
      a_re   = (c == 0) ? 3'b001 : 3'b000;
      a_drop = (c == 2);
      settle();
      chk($sformatf("t6_rv_c%0d", c), a_rv, 0);
      chk($sformatf("t6_err_c%0d", c), a_err, (c >= 3) ? 1 : 0);
      step();
    end

    // T5: READ_LATENCY=3, interleaved 0,1,2,0 accepts
    do_reset();
    t5_re = '{3'b001, 3'b010, 3'b100, 3'b001};
    t5_id = '{0, 1, 2, 0};
    for (int c = 0; c < 10; c++) begin
      b_re = (c < 4) ? t5_re[c] : 3'b000;
      for (int i = 0; i < N; i++) set_b(i, 32 + 4 * c + i);
      settle();
      chk($sformatf("t5_ready_c%0d", c), b_ready, (c < 4) ? t5_re[c] : 3'b000);
      chk($sformatf("t5_rv_c%0d", c), b_rv, (c >= 4 && c < 8) ? t5_re[c-4] : 3'b000);
      if (c >= 4 && c < 8)
        chk($sformatf("t5_rdata_c%0d", c), b_rdata, mem_dat(AW'(32 + 4 * (c - 4) + t5_id[c-4])));
      chk($sformatf("t5_err_c%0d", c), b_err, 0);
      step();
    end

    // T7: reset mid-burst with reads in flight (READ_LATENCY=3)
    do_reset();
    for (int c = 0; c < 3; c++) begin
      b_re = 3'b001;
      set_b(0, 50 + c);
      settle();
      chk($sformatf("t7_ready_c%0d", c), b_ready, 3'b001);
      step();
    end
    b_re = 3'b001;
    set_b(0, 53);
    settle();
    chk("t7_ready_c3", b_ready, 3'b001);
    reset = 1'b0;
    #1;
    chk("t7_rst_ready", b_ready, 0);
    chk("t7_rst_bre", b_bre, 0);
    chk("t7_rst_baddr", b_baddr, 0);
    chk("t7_rst_rv", b_rv, 0);
    chk("t7_rst_err", b_err, 0);
    step();
    reset = 1'b1;
    for (int c = 4; c < 9; c++) begin
      b_re = (c == 4) ? 3'b111 : 3'b000;
      set_b(0, 60);
      settle();
      if (c == 4) chk("t7_first_grant", b_ready, 3'b001);
      if (c == 5) chk("t7_bre_c5", b_bre, 1);
      if (c == 5) chk("t7_baddr_c5", b_baddr, 60);
      chk($sformatf("t7_rv_c%0d", c), b_rv, (c == 8) ? 3'b001 : 3'b000);
      if (c == 8) chk("t7_rdata_c8", b_rdata, mem_dat(AW'(60)));
      chk($sformatf("t7_err_c%0d", c), b_err, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
